tictactoe_game_fsm: RTL
=======================

Name: tictactoe_game_fsm

Overview:
Game-state engine for the Tic-Tac-Toe VGA demo. It sits directly downstream of the cursor/selection block: it consumes the selected cell index and its ready strobe, and applies the move. It owns the 3x3 board, alternates turns, and detects win and draw. Its board bitmaps and status outputs feed the sprite, pointer and RGB printing stages on the VGA clock domain.

Parameters:
FIRST_PLAYER, 0, player who moves first after reset/new_game (0 = P1, 1 = P2)
TIMEOUT_CYCLES, 250000000, idle cycles in PLAY before forced turn pass (only with MOVE_TIMEOUT_EN; 10 s at 25 MHz)

Ports:
clk  input  1  system clock (VGA pixel clock domain)
rst  input  1  asynchronous reset, active-low
move_valid  input  1  one-cycle strobe: move_pos holds a selected cell
move_pos  input  4  cell index 0..8, row-major (0 = top-left)
new_game  input  1  one-cycle strobe: clear board, restart
board_p1  output  9  bit i set = cell i holds P1 mark
board_p2  output  9  bit i set = cell i holds P2 mark
turn  output  1  player to move (0 = P1, 1 = P2)
move_ack  output  1  one-cycle pulse: move accepted
move_err  output  1  one-cycle pulse: move rejected
game_over  output  1  high in OVER state
winner  output  2  00 none, 01 P1, 10 P2, 11 draw
win_line  output  8  one-hot winning line: bits 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal
timeout  output  1  one-cycle pulse: turn forced by timeout (0 when feature absent)

Behaviour:
- Reset (rst=0, async): board_p1=board_p2=0, turn=FIRST_PLAYER, move count=0, state=PLAY, winner=00, win_line=0, all pulses 0, game_over=0.
- The FSM has three states: PLAY, CHECK and OVER.
- PLAY, move_valid=1:
  - If move_pos>8, or the cell is set in either board: assert move_err on the next cycle. No state change.
  - Otherwise, on the next edge: set bit move_pos in the current player's board, increment move count, pulse move_ack, go to CHECK.
- CHECK (exactly one cycle): evaluate the 8 lines against the board of the player who just moved.
  - Any line complete -> OVER, winner = that player, win_line = one-hot of the lowest-index complete line.
  - Else, move count==9 -> OVER, winner=11, win_line=0.
  - Else, toggle turn and return to PLAY.
- Latency: move_valid to move_ack is 1 cycle. move_valid to winner/game_over valid is 2 cycles. move_valid to turn toggle is 2 cycles.
- move_valid while in CHECK or OVER: ignored. No ack and no err.
- OVER: board, winner and win_line are held until new_game or reset. turn is frozen.
- new_game, any state: on the next edge, clear boards, move count, winner and win_line; set turn=FIRST_PLAYER; go to PLAY. It takes priority over a simultaneous move_valid (that move is dropped, no ack/err).
- Invariant: board_p1 & board_p2 == 0 at all times. The move count equals popcount(board_p1|board_p2).
- move_ack and move_err are never both high. Each is high for exactly one cycle per event.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined: a counter (width clog2(TIMEOUT_CYCLES+1)) runs only in PLAY.
  - It clears on reset, new_game, accepted move, and entry to PLAY.
  - On reaching TIMEOUT_CYCLES-1 with no move_valid that cycle: toggle turn, pulse timeout for 1 cycle, restart the counter. The board is unchanged.
  - A move_valid in the same cycle wins over the timeout.
- Not defined: no counter logic; timeout tied to 0; TIMEOUT_CYCLES unused.

Test Plan:
- Reset, then P1 plays cells 0, 1, 2 interleaved with P2 on 3, 4 -> after the move on 2: move_ack at +1, winner=01, win_line=00000001, game_over=1 at +2, board_p1=000000111, board_p2=000011000.
- Play 4 (P1), then 4 again (P2) -> second move gives move_err pulse, board_p2=0, turn stays 1; then move_pos=9 -> move_err again.
- Full draw sequence 0,1,2,4,3,5,7,6,8 -> after the 9th move winner=11, win_line=0; a further move_valid produces neither ack nor err.
- P2 wins on anti-diagonal 2,4,6 -> winner=10, win_line=10000000; new_game and move_valid in the same cycle -> boards 0, turn=FIRST_PLAYER, no move_ack.
- Assert rst low mid-CHECK -> all outputs reset immediately (async), state PLAY after release.
- With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle in PLAY -> timeout pulse and turn toggle after 16 cycles. A move at cycle 15 suppresses the timeout and restarts the count.

Source files
------------

// File: rtl/tictactoe_game_fsm.sv
// rtl/tictactoe_game_fsm.sv - Tic-Tac-Toe game-state engine; optional MOVE_TIMEOUT_EN forced turn pass
module tictactoe_game_fsm #(
    parameter bit FIRST_PLAYER = 1'b0
`ifdef MOVE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 250000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       new_game,
    output logic [8:0] board_p1,
    output logic [8:0] board_p2,
    output logic       turn,
    output logic       move_ack,
    output logic       move_err,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] win_line,
    output logic       timeout
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t      state;
    logic [3:0]  move_cnt;
    logic [8:0]  cur_board;
    logic [8:0]  cell_mask;
    logic [15:0] occupied;
    logic [7:0]  hits;
    logic [7:0]  first_hit;
    logic        bad_move;

    function automatic logic [7:0] line_hits(input logic [8:0] b);
        logic [7:0] h;
        h[0] = &{b[0], b[1], b[2]};
        h[1] = &{b[3], b[4], b[5]};
        h[2] = &{b[6], b[7], b[8]};
        h[3] = &{b[0], b[3], b[6]};
        h[4] = &{b[1], b[4], b[7]};
        h[5] = &{b[2], b[5], b[8]};
        h[6] = &{b[0], b[4], b[8]};
        h[7] = &{b[2], b[4], b[6]};
        return h;
    endfunction

    // In CHECK the turn has not toggled yet, so turn names the player who just moved
    always_comb begin
        cur_board = turn ? board_p2 : board_p1;
        hits      = line_hits(cur_board);
        first_hit = hits & (~hits + 8'd1);
        cell_mask = 9'b1 << move_pos;
        occupied  = {7'b0, board_p1 | board_p2};
        bad_move  = (move_pos > 4'd8) || occupied[move_pos];
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PLAY;
            board_p1  <= '0;
            board_p2  <= '0;
            turn      <= FIRST_PLAYER;
            move_cnt  <= '0;
            move_ack  <= 1'b0;
            move_err  <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            win_line  <= '0;
`ifdef MOVE_TIMEOUT_EN
            timeout   <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            if (new_game) begin
                state     <= PLAY;
                board_p1  <= '0;
                board_p2  <= '0;
                turn      <= FIRST_PLAYER;
                move_cnt  <= '0;
                game_over <= 1'b0;
                winner    <= 2'b00;
                win_line  <= '0;
`ifdef MOVE_TIMEOUT_EN
                tcnt      <= '0;
`endif
            end else begin
                case (state)
                    PLAY: begin
                        if (move_valid) begin
                            if (bad_move) begin
                                move_err <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                                tcnt     <= tcnt + TW'(1);
`endif
                            end else begin
                                if (turn) board_p2 <= board_p2 | cell_mask;
                                else      board_p1 <= board_p1 | cell_mask;
                                move_cnt <= move_cnt + 4'd1;
                                move_ack <= 1'b1;
                                state    <= CHECK;
`ifdef MOVE_TIMEOUT_EN
                                tcnt     <= '0;
`endif
                            end
                        end
`ifdef MOVE_TIMEOUT_EN
                        else if (tcnt >= T_LAST) begin
                            turn    <= ~turn;
                            timeout <= 1'b1;
                            tcnt    <= '0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
`endif
                    end
                    CHECK: begin
`ifdef MOVE_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (|hits) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= turn ? 2'b10 : 2'b01;
                            win_line  <= first_hit;
                        end else if (move_cnt == 4'd9) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= 2'b11;
                            win_line  <= '0;
                        end else begin
                            turn  <= ~turn;
                            state <= PLAY;
                        end
                    end
                    default: begin
                        state <= OVER;
                    end
                endcase
            end
        end
    end

endmodule
